// File: rtl/bsg_mem_1r1w_sync_mask_bypass_synth_pkg.sv
// ============================================================================
// Module   : bsg_mem_1r1w_sync_mask_bypass_synth_pkg
// Brief    : Shared helpers for the 1r1w synthesised memory slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bsg_mem_1r1w_sync_mask_bypass_synth_pkg;

  // A single-entry array still needs a one-bit address port.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_mem_1r1w_mask_synth.sv
// ============================================================================
// Module   : bsg_mem_1r1w_mask_synth
// Brief    : Masked-write array with asynchronous read mux; out-of-range
//            writes are dropped and out-of-range reads return zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_mem_1r1w_mask_synth
  import bsg_mem_1r1w_sync_mask_bypass_synth_pkg::*;
#(
  parameter  int width_p       = 36,
  parameter  int els_p         = 2,
  localparam int addr_width_lp = safe_clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [width_p-1:0]       w_mask_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  localparam logic [addr_width_lp:0] c_els = els_p[addr_width_lp:0];

  logic [width_p-1:0] r_mem [els_p];
  logic               w_w_in_range;
  logic               w_r_in_range;

  assign w_w_in_range = ({1'b0, w_addr_i} < c_els);
  assign w_r_in_range = ({1'b0, r_addr_i} < c_els);

  // Storage is intentionally not reset; only the write port touches it.
  always_ff @(posedge w_clk_i) begin
    if (!w_reset_i && w_v_i && w_w_in_range) begin
      r_mem[w_addr_i] <= (r_mem[w_addr_i] & ~w_mask_i) | (w_data_i & w_mask_i);
    end
  end

  assign r_data_o = w_r_in_range ? r_mem[r_addr_i] : '0;

endmodule

`default_nettype wire

// File: rtl/bsg_mem_1r1w_sync_mask_bypass_synth.sv
// ============================================================================
// Module   : bsg_mem_1r1w_sync_mask_bypass_synth
// Brief    : 1r1w memory with registered read, per-bit write mask, optional
//            write-to-read bypass and optional hold of the last read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_mem_1r1w_sync_mask_bypass_synth
  import bsg_mem_1r1w_sync_mask_bypass_synth_pkg::*;
#(
  parameter  int width_p                = 36,
  parameter  int els_p                  = 2,
  parameter  int read_write_same_addr_p = 0,
  parameter  int latch_last_read_p      = 1,
  localparam int addr_width_lp          = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [width_p-1:0]       w_mask_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o,
  output logic                     r_v_o
);

  localparam logic [addr_width_lp:0] c_els = els_p[addr_width_lp:0];

  logic [width_p-1:0] w_mem_data;
  logic [width_p-1:0] w_rd_data;
  logic               w_collide;
  logic [width_p-1:0] r_data_q;
  logic               r_v_q;

  bsg_mem_1r1w_mask_synth #(
    .width_p (width_p),
    .els_p   (els_p)
  ) u_mem (
    .w_clk_i   (clk_i),
    .w_reset_i (reset_i),
    .w_v_i     (w_v_i),
    .w_addr_i  (w_addr_i),
    .w_data_i  (w_data_i),
    .w_mask_i  (w_mask_i),
    .r_addr_i  (r_addr_i),
    .r_data_o  (w_mem_data)
  );

  // An out-of-range read returns zero even if an equal write address is presented.
  assign w_collide = r_v_i & w_v_i & (r_addr_i == w_addr_i)
                   & ({1'b0, r_addr_i} < c_els);

  generate
    if (read_write_same_addr_p != 0) begin : g_bypass
      assign w_rd_data = w_collide
                       ? ((w_mem_data & ~w_mask_i) | (w_data_i & w_mask_i))
                       : w_mem_data;
    end else begin : g_no_bypass
      assign w_rd_data = w_mem_data;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_data_q <= '0;
      r_v_q    <= 1'b0;
    end else if (r_v_i) begin
      r_data_q <= w_rd_data;
      r_v_q    <= 1'b1;
    end else begin
      r_v_q <= 1'b0;
      if (latch_last_read_p == 0) begin
        r_data_q <= '0;
      end
    end
  end

  assign r_data_o = r_data_q;
  assign r_v_o    = r_v_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (read_write_same_addr_p != 0 || !w_collide)
        else $error("bsg_mem_1r1w_sync_mask_bypass_synth: read/write collision at addr %0d", r_addr_i);
      assert (!(w_v_i && $isunknown(w_addr_i)))
        else $error("bsg_mem_1r1w_sync_mask_bypass_synth: unknown w_addr_i with w_v_i");
      assert (!(r_v_i && $isunknown(r_addr_i)))
        else $error("bsg_mem_1r1w_sync_mask_bypass_synth: unknown r_addr_i with r_v_i");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_mem_1r1w_sync_mask_bypass_synth.sv
// ============================================================================
// Module   : tb_bsg_mem_1r1w_sync_mask_bypass_synth
// Brief    : Directed + random bench for two bypass builds (latch on / off).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_mem_1r1w_sync_mask_bypass_synth;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_v;
  logic [2:0]  w_addr;
  logic [35:0] w_data;
  logic [35:0] w_mask;
  logic        r_v;
  logic [2:0]  r_addr;
  logic [35:0] r_data1;
  logic        r_v1;
  logic [35:0] r_data0;
  logic        r_v0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: memory contents and the expected output registers.
  logic [35:0] m_mem [5];
  logic [35:0] m_d1;
  logic [35:0] m_d0;
  logic        m_v;

  localparam logic [35:0] ONES = 36'hF_FFFF_FFFF;

  always #5 clk = ~clk;

  bsg_mem_1r1w_sync_mask_bypass_synth #(
    .width_p                (36),
    .els_p                  (5),
    .read_write_same_addr_p (1),
    .latch_last_read_p      (1)
  ) dut_latch (
    .clk_i    (clk),
    .reset_i  (reset),
    .w_v_i    (w_v),
    .w_addr_i (w_addr),
    .w_data_i (w_data),
    .w_mask_i (w_mask),
    .r_v_i    (r_v),
    .r_addr_i (r_addr),
    .r_data_o (r_data1),
    .r_v_o    (r_v1)
  );

  bsg_mem_1r1w_sync_mask_bypass_synth #(
    .width_p                (36),
    .els_p                  (5),
    .read_write_same_addr_p (1),
    .latch_last_read_p      (0)
  ) dut_clear (
    .clk_i    (clk),
    .reset_i  (reset),
    .w_v_i    (w_v),
    .w_addr_i (w_addr),
    .w_data_i (w_data),
    .w_mask_i (w_mask),
    .r_v_i    (r_v),
    .r_addr_i (r_addr),
    .r_data_o (r_data0),
    .r_v_o    (r_v0)
  );

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Drive one cycle, advance the reference by the spec rules, then compare.
  task automatic step(input logic rst, input logic wv, input logic [2:0] wa,
                      input logic [35:0] wd, input logic [35:0] wm,
                      input logic rv, input logic [2:0] ra, input string tag);
    logic [35:0] rd;
    reset  = rst;
    w_v    = wv;
    w_addr = wa;
    w_data = wd;
    w_mask = wm;
    r_v    = rv;
    r_addr = ra;
    if (rst) begin
      m_d1 = '0;
      m_d0 = '0;
      m_v  = 1'b0;
    end else begin
      rd = (ra < 3'd5) ? m_mem[ra] : 36'h0;
      if (rv && wv && (wa == ra) && (ra < 3'd5)) rd = (rd & ~wm) | (wd & wm);
      if (rv) begin
        m_d1 = rd;
        m_d0 = rd;
        m_v  = 1'b1;
      end else begin
        m_d0 = '0;
        m_v  = 1'b0;
      end
      if (wv && (wa < 3'd5)) m_mem[wa] = (m_mem[wa] & ~wm) | (wd & wm);
    end
    @(posedge clk);
    #1;
    check({tag, ".data_latch"}, r_data1, m_d1);
    check({tag, ".v_latch"}, {35'b0, r_v1}, {35'b0, m_v});
    check({tag, ".data_clear"}, r_data0, m_d0);
    check({tag, ".v_clear"}, {35'b0, r_v0}, {35'b0, m_v});
  endtask

  initial begin
    logic [35:0] rd_data;
    logic [35:0] rd_mask;
    reset  = 1'b1;
    w_v    = 1'b0;
    w_addr = '0;
    w_data = '0;
    w_mask = '0;
    r_v    = 1'b0;
    r_addr = '0;

    // Reset held with a read request pending, then one idle cycle after release.
    step(1'b1, 1'b0, 3'd0, 36'h0, 36'h0, 1'b1, 3'd0, "rst0");
    step(1'b1, 1'b0, 3'd0, 36'h0, 36'h0, 1'b1, 3'd0, "rst1");
    step(1'b0, 1'b0, 3'd0, 36'h0, 36'h0, 1'b0, 3'd0, "post_rst");
    check("post_rst.const_zero", r_data1, 36'h0);

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 3'(i), 36'h0_0000_1000 * 36'(i + 1), ONES, 1'b0, 3'd0, "prefill");
    end

    step(1'b0, 1'b1, 3'd4, 36'hA_BCDE_F012, ONES, 1'b0, 3'd0, "wr4");
    step(1'b0, 1'b0, 3'd0, 36'h0, 36'h0, 1'b1, 3'd4, "rd4");
    check("rd4.literal", r_data1, 36'hA_BCDE_F012);

    step(1'b0, 1'b1, 3'd1, ONES, ONES, 1'b0, 3'd0, "wr1_ones");
    step(1'b0, 1'b1, 3'd1, 36'h0, 36'h0_0000_00FF, 1'b0, 3'd0, "wr1_mask");
    step(1'b0, 1'b0, 3'd0, 36'h0, 36'h0, 1'b1, 3'd1, "rd1");
    check("rd1.literal", r_data1, 36'hF_FFFF_FF00);

    step(1'b0, 1'b1, 3'd2, 36'h1_1111_1111, ONES, 1'b0, 3'd0, "wr2");
    step(1'b0, 1'b1, 3'd2, 36'h2_2222_2222, 36'hF_0000_0000, 1'b1, 3'd2, "bypass2");
    check("bypass2.literal", r_data1, 36'h2_1111_1111);
    step(1'b0, 1'b0, 3'd0, 36'h0, 36'h0, 1'b1, 3'd2, "rd2_after");

    step(1'b0, 1'b1, 3'd3, 36'h0_0000_0123, ONES, 1'b0, 3'd0, "wr3");
    step(1'b0, 1'b0, 3'd0, 36'h0, 36'h0, 1'b1, 3'd3, "rd3");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 3'd0, 36'h0, 36'h0, 1'b0, 3'd0, "idle_hold");
      check("idle_hold.literal", r_data1, 36'h0_0000_0123);
    end

    step(1'b0, 1'b1, 3'd6, 36'h5_5555_5555, ONES, 1'b0, 3'd0, "wr_oor");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 3'd0, 36'h0, 36'h0, 1'b1, 3'(i), "rd_after_oor");
    end
    step(1'b0, 1'b0, 3'd0, 36'h0, 36'h0, 1'b1, 3'd6, "rd_oor");
    step(1'b0, 1'b0, 3'd0, 36'h0, 36'h0, 1'b1, 3'd4, "rd_before_rst");
    step(1'b1, 1'b0, 3'd0, 36'h0, 36'h0, 1'b1, 3'd4, "rst_mid_read");
    check("rst_mid_read.literal", r_data1, 36'h0);

    for (int i = 0; i < 400; i++) begin
      rd_data = {4'($urandom), $urandom};
      rd_mask = ($urandom_range(0, 3) == 0) ? ONES : {4'($urandom), $urandom};
      step(($urandom_range(0, 29) == 0), 1'($urandom), 3'($urandom_range(0, 7)),
           rd_data, rd_mask, 1'($urandom), 3'($urandom_range(0, 7)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
